regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised general-purpose register file for the CPU datapath.
- Two combinational read ports, one synchronous write port, with write-to-read forwarding.
- Optional hardwired-zero register x0.
- Serial dump engine streams every register out over a valid/ready handshake, for debug through the narrow top-level IO.
- Replaces the fixed 8x6 single-port register block. All state is on the rising edge of clk.

Parameters:
DATA_W, 6, register width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  in  1  system clock, rising edge active
reset  in  1  synchronous, active-high reset
rs1_addr  in  ADDR_W  read port 1 address
rs1_data  out  DATA_W  read port 1 data (combinational)
rs2_addr  in  ADDR_W  read port 2 address
rs2_data  out  DATA_W  read port 2 data (combinational)
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
dump_start  in  1  single-cycle request to stream all registers
dump_busy  out  1  high while a dump is in progress
dump_valid  out  1  dump_data/dump_addr hold a valid element
dump_ready  in  1  consumer accepts the current element
dump_addr  out  ADDR_W  index of the element being presented
dump_data  out  DATA_W  value of the element being presented

Behaviour:
- One clock (clk) and one synchronous, active-high reset (reset); the polarity and synchronicity are fixed.
- Reset (sampled at a clk rising edge):
  - all DEPTH registers are cleared to 0;
  - dump FSM goes to IDLE;
  - dump_busy, dump_valid, dump_addr and dump_data are 0;
  - reset wins over any simultaneous wr_en or dump_start.
- Write:
  - at a rising edge with wr_en=1, registers[wr_addr] <= wr_data;
  - if ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency), for each port N:
  - ZERO_REG=1 and rsN_addr=0 -> 0;
  - else if wr_en=1 and wr_addr=rsN_addr -> wr_data (forwarding);
  - else registers[rsN_addr].
  - Both ports may read the same address; there is no ordering between them.
- Dump FSM states and transitions:
  - IDLE: dump_busy=0, dump_valid=0. dump_start=1 -> ptr<=0, go to FETCH.
  - FETCH (1 cycle): dump_busy=1, dump_valid=0. dump_data <= read value of registers[ptr], using the same zero and forwarding rules as the read ports. dump_addr <= ptr. Go to SEND.
  - SEND: dump_busy=1, dump_valid=1.
    - dump_data and dump_addr hold stable until dump_ready=1.
    - Writes to that address during SEND do not alter dump_data.
    - On dump_ready=1: if ptr=DEPTH-1, go to IDLE (dump_valid and dump_busy fall next cycle); else ptr<=ptr+1 and go to FETCH.
- Dump throughput: one element per 2 cycles at best. A full dump with dump_ready held at 1 takes 2*DEPTH cycles from the cycle after dump_start to IDLE.
- dump_start is ignored outside IDLE.
- dump_ready is ignored outside SEND.
- Register writes and reads are fully functional during a dump.
- Reset mid-dump aborts immediately and returns all outputs to their reset values.
- ptr is ADDR_W bits wide and never wraps: the terminal check is done before the increment.
- The dump is a snapshot per element, taken at that element's FETCH cycle. It is not a coherent snapshot of the whole file.

Decomposition:
- Package regfile_pkg:
  - dump state enum: IDLE=2'd0, FETCH=2'd1, SEND=2'd2;
  - default DATA_W/ADDR_W constants, shared with the CPU top.
- Sub-module regfile_dump_ctrl:
  - contains the FSM, ptr and output registers;
  - reads through a dedicated third combinational read port exported by the storage array.
- The storage array, write logic and forwarding stay in regfile_multiport.

Test Plan:
1. Reset and zero register: reset=1 for 1 cycle, then read every address on both ports -> all 0. Then wr_en=1, wr_addr=0, wr_data=6'h2A -> rs1_addr=0 reads 0 (ZERO_REG=1). With ZERO_REG=0 the same sequence reads 6'h2A.
2. Write and forwarding: write 6'h15 to address 3 -> same cycle rs1_addr=3 reads 6'h15 (forwarded). Next cycle with wr_en=0 -> still 6'h15. rs2_addr=5 reads 0 throughout.
3. Dual-port read: write 6'h11 to address 1 and 6'h22 to address 2, then rs1_addr=1, rs2_addr=2 -> 6'h11 and 6'h22. Both ports at address 2 -> 6'h22 on both.
4. Full dump, free-running: load registers 1..7 with value 6'h10+i, pulse dump_start, hold dump_ready=1 -> 8 handshakes with addr/data pairs (0,0),(1,6'h11)...(7,6'h17). dump_busy stays high for exactly 16 cycles.
5. Dump backpressure and concurrent write: dump_ready=0 for 5 cycles while address 2 is presented, and a write of 6'h3F to address 2 occurs during that time -> dump_data holds its old value until accepted. Later reads of address 2 return 6'h3F. dump_start pulses mid-dump are ignored.
6. Reset mid-dump: assert reset while in SEND at dump_addr=4 -> next cycle dump_busy=0, dump_valid=0, dump_addr=0, dump_data=0, all registers 0. A new dump_start restarts from address 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
// Holds the default geometry (also used by the CPU top) and the dump
// engine state encoding. There are no ports; this is a package.
package regfile_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_FETCH = 2'd1,
    DUMP_SEND  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport.
// Groups the two read ports, the write port and the dump stream.
//   master : the user side (CPU datapath or debug consumer)
//   slave  : the register file
// dump_state is a debug view of the dump engine state.
//
// Dump stream handshake: the slave raises dump_valid with dump_addr and
// dump_data and keeps all three stable until it samples dump_ready=1 at a
// rising clk edge; that edge is the transfer. dump_ready is only meaningful
// while dump_valid=1, and the master may drive it freely at any time.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  dump_state_e       dump_state;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    input  rs1_data, rs2_data, dump_busy, dump_valid, dump_addr, dump_data,
           dump_state
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    output rs1_data, rs2_data, dump_busy, dump_valid, dump_addr, dump_data,
           dump_state
  );

endinterface

// File: rtl/regfile_dump_ctrl.sv
// Serial dump engine for the register file.
// Walks ptr from 0 to DEPTH-1. Each element takes one FETCH cycle, in which
// the value is captured from the storage array's dedicated read port, and
// at least one SEND cycle, in which it is offered on the valid/ready stream.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   dump_start, dump_ready  request / consumer acceptance
//   dump_busy, dump_valid   status / element valid
//   dump_addr, dump_data    presented element
//   rd_addr, rd_data        third read port into the storage array
//   state                   debug view of the FSM state
module regfile_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output dump_state_e       state
);

  localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          ptr_d   = '0;
          state_d = DUMP_FETCH;
        end
      end
      DUMP_FETCH: begin
        // Snapshot taken here; later writes to this address do not reach
        // the presented element.
        data_d  = rd_data;
        addr_d  = ptr_q;
        state_d = DUMP_SEND;
      end
      DUMP_SEND: begin
        if (dump_ready) begin
          // Terminal test before the increment, so ptr never wraps.
          if (ptr_q == LAST_PTR) begin
            state_d = DUMP_IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = DUMP_FETCH;
          end
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dump_busy  = (state_q != DUMP_IDLE);
  assign dump_valid = (state_q == DUMP_SEND);
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign rd_addr    = ptr_q;
  assign state      = state_q;

endmodule

// File: rtl/regfile_multiport.sv
// General-purpose register file: DEPTH = 2**ADDR_W registers of DATA_W bits,
// two combinational read ports, one synchronous write port with
// write-to-read forwarding, optional hardwired-zero register 0, and a
// serial dump engine on a valid/ready stream.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears every register and the dump engine
//   bus    regfile_multiport_if.slave (read, write and dump signals)
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_multiport_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;

  // Shared read rule for all three read ports: hardwired zero first, then
  // the in-flight write, then the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] val;
    if (ZERO_REG && (addr == '0)) begin
      val = '0;
    end else if (we && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0))) begin
      regs_d[bus.wr_addr] = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.rs1_data = read_port(bus.rs1_addr, regs_q[bus.rs1_addr],
                                  bus.wr_en, bus.wr_addr, bus.wr_data);
  assign bus.rs2_data = read_port(bus.rs2_addr, regs_q[bus.rs2_addr],
                                  bus.wr_en, bus.wr_addr, bus.wr_data);
  assign dump_rd_data = read_port(dump_rd_addr, regs_q[dump_rd_addr],
                                  bus.wr_en, bus.wr_addr, bus.wr_data);

  regfile_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .dump_busy  (bus.dump_busy),
    .dump_valid (bus.dump_valid),
    .dump_addr  (bus.dump_addr),
    .dump_data  (bus.dump_data),
    .rd_addr    (dump_rd_addr),
    .rd_data    (dump_rd_data),
    .state      (bus.dump_state)
  );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: one instance with ZERO_REG=1 driven directly,
// a second with ZERO_REG=0 that mirrors the same read/write inputs.
module tb_regfile_multiport;
  import regfile_pkg::*;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
  localparam int EW     = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  regfile_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nz ();

  regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  regfile_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) u_dut_nz (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nz.slave)
  );

  assign bus_nz.rs1_addr   = bus.rs1_addr;
  assign bus_nz.rs2_addr   = bus.rs2_addr;
  assign bus_nz.wr_en      = bus.wr_en;
  assign bus_nz.wr_addr    = bus.wr_addr;
  assign bus_nz.wr_data    = bus.wr_data;
  assign bus_nz.dump_start = 1'b0;
  assign bus_nz.dump_ready = 1'b0;

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  int hs_cnt;
  logic [DATA_W-1:0] mdl_z  [DEPTH];
  logic [DATA_W-1:0] mdl_nz [DEPTH];
  logic [EW-1:0]     exp_q[$];
  logic              hold_pend;
  logic [EW-1:0]     hold_val;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
    logic [DATA_W-1:0] e1_nz;
    logic [DATA_W-1:0] e2_nz;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model read: zero register, then forwarding, then stored contents.
  function automatic logic [DATA_W-1:0] ref_read(input bit zero, input logic [ADDR_W-1:0] a);
    if (zero && a == '0) return '0;
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
    return zero ? mdl_z[a] : mdl_nz[a];
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock, update the register model from the inputs seen at the
  // edge, and return 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdl_z[i]  = '0;
        mdl_nz[i] = '0;
      end
      exp_q.delete();
      hold_pend = 1'b0;
    end else if (bus.wr_en) begin
      if (bus.wr_addr != '0) mdl_z[bus.wr_addr] = bus.wr_data;
      mdl_nz[bus.wr_addr] = bus.wr_data;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rs1_addr = r1;
    bus.rs2_addr = r2;
  endtask

  task automatic check_reads(input string tag);
    chk({tag, "_rs1"},    32'(bus.rs1_data),    32'(ref_read(1'b1, bus.rs1_addr)));
    chk({tag, "_rs2"},    32'(bus.rs2_data),    32'(ref_read(1'b1, bus.rs2_addr)));
    chk({tag, "_nz_rs1"}, 32'(bus_nz.rs1_data), 32'(ref_read(1'b0, bus.rs1_addr)));
    chk({tag, "_nz_rs2"}, 32'(bus_nz.rs2_data), 32'(ref_read(1'b0, bus.rs2_addr)));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.dump_busy),  32'd0);
    chk({tag, "_valid"}, 32'(bus.dump_valid), 32'd0);
    chk({tag, "_addr"},  32'(bus.dump_addr),  32'd0);
    chk({tag, "_data"},  32'(bus.dump_data),  32'd0);
    chk({tag, "_state"}, 32'(bus.dump_state), 32'(DUMP_IDLE));
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rs1_addr = ADDR_W'(a);
      bus.rs2_addr = ADDR_W'(DEPTH - 1 - a);
      #1;
      chk({tag, "_rs1"},    32'(bus.rs1_data),    32'd0);
      chk({tag, "_rs2"},    32'(bus.rs2_data),    32'd0);
      chk({tag, "_nz_rs1"}, 32'(bus_nz.rs1_data), 32'd0);
      chk({tag, "_nz_rs2"}, 32'(bus_nz.rs2_data), 32'd0);
    end
  endtask

  // Waits for the dump to finish with a cycle budget.
  task automatic wait_dump_done(input string tag, input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (!bus.dump_busy) done = 1'b1;
      else begin
        if (rand_ready) bus.dump_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    bus.dump_ready = 1'b0;
  endtask

  // ---------------- stream monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_without_busy", 32'(bus.dump_valid & ~bus.dump_busy), 32'd0);
      if (bus.dump_valid) begin
        if (hold_pend) chk("dump_hold", 32'({bus.dump_addr, bus.dump_data}), 32'(hold_val));
        if (bus.dump_ready) begin
          if (exp_q.size() == 0) begin
            chk("dump_unexpected", 32'({bus.dump_addr, bus.dump_data}), 32'hFFFF_FFFF);
          end else begin
            chk("dump_elem", 32'({bus.dump_addr, bus.dump_data}), 32'(exp_q.pop_front()));
          end
          hs_cnt++;
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_val  = {bus.dump_addr, bus.dump_data};
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int busy_cnt;
    bit found;
    checks    = 0;
    errors    = 0;
    hs_cnt    = 0;
    hold_pend = 1'b0;
    hold_val  = '0;

    vecs[0] = '{1'b1, 3'd0, 6'h2A, 3'd0, 3'd0, 6'h00, 6'h00, 6'h2A, 6'h2A};
    vecs[1] = '{1'b0, 3'd0, 6'h00, 3'd0, 3'd3, 6'h00, 6'h00, 6'h2A, 6'h00};
    vecs[2] = '{1'b1, 3'd3, 6'h15, 3'd3, 3'd5, 6'h15, 6'h00, 6'h15, 6'h00};
    vecs[3] = '{1'b0, 3'd0, 6'h00, 3'd3, 3'd5, 6'h15, 6'h00, 6'h15, 6'h00};
    vecs[4] = '{1'b1, 3'd1, 6'h11, 3'd2, 3'd1, 6'h00, 6'h11, 6'h00, 6'h11};
    vecs[5] = '{1'b1, 3'd2, 6'h22, 3'd1, 3'd2, 6'h11, 6'h22, 6'h11, 6'h22};
    vecs[6] = '{1'b0, 3'd0, 6'h00, 3'd1, 3'd2, 6'h11, 6'h22, 6'h11, 6'h22};
    vecs[7] = '{1'b0, 3'd0, 6'h00, 3'd2, 3'd2, 6'h22, 6'h22, 6'h22, 6'h22};
    vecs[8] = '{1'b1, 3'd2, 6'h05, 3'd2, 3'd3, 6'h05, 6'h15, 6'h05, 6'h15};
    vecs[9] = '{1'b0, 3'd0, 6'h00, 3'd2, 3'd0, 6'h05, 6'h00, 6'h05, 6'h2A};

    // Reset with a simultaneous write and dump request that must lose.
    reset          = 1'b1;
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b0;
    drive(1'b1, 3'd4, 6'h3C, 3'd0, 3'd0);
    tick();
    reset          = 1'b0;
    bus.dump_start = 1'b0;
    drive(1'b0, 3'd0, 6'h00, 3'd0, 3'd0);
    #1;
    check_idle_outputs("reset");
    check_all_zero("reset_read");

    // Table: zero register, write, forwarding, dual-port reads.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d_rs1", i),    32'(bus.rs1_data),    32'(vecs[i].e1));
      chk($sformatf("vec%0d_rs2", i),    32'(bus.rs2_data),    32'(vecs[i].e2));
      chk($sformatf("vec%0d_nz_rs1", i), 32'(bus_nz.rs1_data), 32'(vecs[i].e1_nz));
      chk($sformatf("vec%0d_nz_rs2", i), 32'(bus_nz.rs2_data), 32'(vecs[i].e2_nz));
      tick();
    end

    // Random reads and writes checked against the register model.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
            DATA_W'($urandom), ADDR_W'($urandom_range(0, DEPTH - 1)),
            ADDR_W'($urandom_range(0, DEPTH - 1)));
      #1;
      check_reads("rand");
      tick();
    end

    // Full dump, consumer always ready.
    for (int i = 1; i < DEPTH; i++) begin
      drive(1'b1, ADDR_W'(i), DATA_W'(6'h10 + i), 3'd0, 3'd0);
      tick();
    end
    drive(1'b0, 3'd0, 6'h00, 3'd0, 3'd0);
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), (a == 0) ? 6'h00 : DATA_W'(6'h10 + a)});
    hs_cnt         = 0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    busy_cnt = 0;
    found    = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (!bus.dump_busy) found = 1'b1;
      else begin
        busy_cnt++;
        tick();
      end
    end
    chk("free_dump_done", 32'(found), 32'd1);
    chk("free_dump_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("free_dump_handshakes", 32'(hs_cnt), 32'd8);
    chk("free_dump_queue_left", 32'(exp_q.size()), 32'd0);
    bus.dump_ready = 1'b0;

    // Backpressure on address 2 with a concurrent write and ignored starts.
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), (a == 0) ? 6'h00 : DATA_W'(6'h10 + a)});
    hs_cnt         = 0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus.dump_valid && bus.dump_addr == 3'd2) found = 1'b1;
      else tick();
    end
    chk("bp_reach_addr2", 32'(found), 32'd1);
    bus.dump_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus.dump_valid), 32'd1);
      chk("bp_data", 32'(bus.dump_data), 32'h12);
      drive(k == 1, 3'd2, 6'h3F, 3'd2, 3'd2);
      bus.dump_start = (k == 2);
      tick();
    end
    drive(1'b0, 3'd0, 6'h00, 3'd2, 3'd2);
    bus.dump_start = 1'b0;
    bus.dump_ready = 1'b1;
    wait_dump_done("bp_dump", 1'b0);
    chk("bp_handshakes", 32'(hs_cnt), 32'd8);
    chk("bp_queue_left", 32'(exp_q.size()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_no_restart", 32'(bus.dump_busy), 32'd0);
      tick();
    end
    #1;
    chk("bp_read_addr2", 32'(bus.rs1_data), 32'h3F);

    // Random backpressure dump over the current contents.
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), mdl_z[a]});
    hs_cnt         = 0;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    wait_dump_done("rand_dump", 1'b1);
    chk("rand_dump_handshakes", 32'(hs_cnt), 32'd8);
    chk("rand_dump_queue_left", 32'(exp_q.size()), 32'd0);

    // Reset while presenting address 4.
    hs_cnt         = 0;
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), mdl_z[a]});
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus.dump_valid && bus.dump_addr == 3'd4) found = 1'b1;
      else tick();
    end
    chk("rst_reach_addr4", 32'(found), 32'd1);
    bus.dump_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_reset");
    check_all_zero("mid_reset_read");

    // Restart after reset: every element is zero, starting at address 0.
    for (int a = 0; a < DEPTH; a++) exp_q.push_back({ADDR_W'(a), 6'h00});
    hs_cnt         = 0;
    bus.dump_ready = 1'b1;
    bus.dump_start = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    wait_dump_done("restart_dump", 1'b0);
    chk("restart_handshakes", 32'(hs_cnt), 32'd8);
    chk("restart_queue_left", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
